// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer: FSM state encodings,
// the read-to-output pipeline latency and the runtime length clamp rule.
package fft_reorder_pkg;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_FILL = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_DRAIN = 1'b1
   } rd_state_e;

   // Cycles from read-address issue to the registered output sample.
   localparam int unsigned RD_LATENCY = 2;

   // Lengths below 4 points or above the bank depth fall back to the maximum.
   function automatic int unsigned clamp_len(input int unsigned len_log2,
                                             input int unsigned n_log2_max);
      if (len_log2 < 2 || len_log2 > n_log2_max) begin
         return n_log2_max;
      end
      return len_log2;
   endfunction

endpackage

// File: rtl/fft_reorder_bank_ram.sv
// Simple dual-port RAM for one reorder bank: one write port and one
// registered read port on a shared clock. Contents are not reset.
module fft_reorder_bank_ram #(
   parameter int ADDR_W = 10,
   parameter int WIDTH  = 50
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port and registered read port; write and read never share a bank
   // in the same cycle, so no read-during-write behaviour is relied upon.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_reorder_pingpong.sv
// Ping-pong reorder buffer after the radix-2^2 SDF FFT: writes bit-reversed
// samples into one bank while the other bank drains in natural order.
// Optional build macro FFT_REORDER_FFTSHIFT_EN: drain in fftshift order
// (-N/2..N/2-1) with a sign-extended bin index.
module fft_reorder_pingpong
   import fft_reorder_pkg::*;
#(
   parameter int N_LOG2_MAX = 10,
   parameter int DATA_WIDTH = 25,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n,
   input  logic [LEN_WIDTH-1:0]         len_log2_i,
   input  logic                         valid_i,
   input  logic                         sync_i,
   input  logic signed [DATA_WIDTH-1:0] data_re_i,
   input  logic signed [DATA_WIDTH-1:0] data_im_i,
   output logic                         valid_o,
   output logic                         sync_o,
   output logic [N_LOG2_MAX-1:0]        bin_o,
   output logic signed [DATA_WIDTH-1:0] data_re_o,
   output logic signed [DATA_WIDTH-1:0] data_im_o,
   output logic                         frame_err_o
);

   localparam int NW = N_LOG2_MAX;
   localparam int LW = LEN_WIDTH;
   localparam int RW = 2 * DATA_WIDTH;
   localparam logic [NW-1:0] CNT_ONE = NW'(1);

   // All-ones mask of the low l bits, i.e. 2^l - 1.
   function automatic logic [NW-1:0] len_mask(input logic [LW-1:0] l);
      return NW'((32'd1 << l) - 32'd1);
   endfunction

   // Reverse the low l bits of v; upper bits come out zero.
   function automatic logic [NW-1:0] bitrev_l(input logic [NW-1:0] v,
                                              input logic [LW-1:0] l);
      logic [NW-1:0] r;
      r = {<<{v}};
      return r >> (NW - int'(l));
   endfunction

`ifdef FFT_REORDER_FFTSHIFT_EN
   // Weight of bit l-1, i.e. 2^(l-1).
   function automatic logic [NW-1:0] half_bit(input logic [LW-1:0] l);
      return NW'(32'd1 << (int'(l) - 1));
   endfunction
`endif

   // Write side state
   wr_state_e        wstate_q, wstate_d;
   logic [NW-1:0]    wcnt_q, wcnt_d;
   logic [LW-1:0]    wlen_q, wlen_d;
   logic             wbank_q, wbank_d;
   logic             wr_en;
   logic [NW-1:0]    wr_addr;
   logic             hand_v;
   logic [LW-1:0]    len_clamped;

   // Read side state
   rd_state_e        rstate_q, rstate_d;
   logic [NW-1:0]    rcnt_q, rcnt_d;
   logic [LW-1:0]    rlen_q, rlen_d;
   logic             rbank_q, rbank_d;
   logic             rlast;

   // Read pipeline
   logic             vld_p0;
   logic [NW-1:0]    raddr_p0;
   logic [NW-1:0]    bin_p0;
   logic             vld_p1_q, vld_p1_d;
   logic             sync_p1_q, sync_p1_d;
   logic [NW-1:0]    bin_p1_q, bin_p1_d;
   logic             bank_p1_q, bank_p1_d;

   // Output registers
   logic                         valid_q, valid_d;
   logic                         sync_q, sync_d;
   logic [NW-1:0]                bin_q, bin_d;
   logic signed [DATA_WIDTH-1:0] re_q, re_d;
   logic signed [DATA_WIDTH-1:0] im_q, im_d;
   logic                         err_q, err_d;

   // Bank ports
   logic [1:0]    ram_we;
   logic [1:0]    ram_re;
   logic [RW-1:0] ram_rdata [2];
   logic [RW-1:0] rd_word;

   assign len_clamped = LW'(clamp_len(32'(len_log2_i), N_LOG2_MAX));

   // Write FSM: latch length on sync, scatter samples to bit-reversed addresses,
   // hand the bank over on the last sample of the frame.
   always_comb begin
      wstate_d = wstate_q;
      wcnt_d   = wcnt_q;
      wlen_d   = wlen_q;
      wbank_d  = wbank_q;
      wr_en    = 1'b0;
      wr_addr  = '0;
      hand_v   = 1'b0;
      err_d    = 1'b0;
      unique case (wstate_q)
         W_IDLE: begin
            if (valid_i && sync_i) begin
               wr_en    = 1'b1;
               wcnt_d   = CNT_ONE;
               wlen_d   = len_clamped;
               wstate_d = W_FILL;
            end
         end
         W_FILL: begin
            if (valid_i && sync_i) begin
               // Early sync: drop the partial frame, restart in the same bank.
               err_d  = 1'b1;
               wr_en  = 1'b1;
               wcnt_d = CNT_ONE;
               wlen_d = len_clamped;
            end else if (valid_i) begin
               wr_en   = 1'b1;
               wr_addr = bitrev_l(wcnt_q, wlen_q);
               if (wcnt_q == len_mask(wlen_q)) begin
                  hand_v   = 1'b1;
                  wbank_d  = ~wbank_q;
                  wcnt_d   = '0;
                  wstate_d = W_IDLE;
               end else begin
                  wcnt_d = wcnt_q + CNT_ONE;
               end
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   assign rlast = (rcnt_q == len_mask(rlen_q));

   // Read FSM: drain a handed-over bank one sample per cycle, chaining
   // directly into the next bank when a handoff lands on the final cycle.
   always_comb begin
      rstate_d = rstate_q;
      rcnt_d   = rcnt_q;
      rlen_d   = rlen_q;
      rbank_d  = rbank_q;
      unique case (rstate_q)
         R_IDLE: begin
            if (hand_v) begin
               rstate_d = R_DRAIN;
               rcnt_d   = '0;
               rlen_d   = wlen_q;
               rbank_d  = wbank_q;
            end
         end
         R_DRAIN: begin
            if (rlast) begin
               rcnt_d = '0;
               if (hand_v) begin
                  rlen_d  = wlen_q;
                  rbank_d = wbank_q;
               end else begin
                  rstate_d = R_IDLE;
               end
            end else begin
               rcnt_d = rcnt_q + CNT_ONE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Stage p0: read address and bin index for the current drain position.
   always_comb begin
      vld_p0 = (rstate_q == R_DRAIN);
`ifdef FFT_REORDER_FFTSHIFT_EN
      raddr_p0 = rcnt_q ^ half_bit(rlen_q);
      bin_p0   = rcnt_q - half_bit(rlen_q);
`else
      raddr_p0 = rcnt_q;
      bin_p0   = rcnt_q;
`endif
      ram_we[0] = wr_en && !wbank_q;
      ram_we[1] = wr_en &&  wbank_q;
      ram_re[0] = vld_p0 && !rbank_q;
      ram_re[1] = vld_p0 &&  rbank_q;
   end

   // Stage p1: RAM data is valid; carry the qualifiers alongside it.
   always_comb begin
      vld_p1_d  = vld_p0;
      sync_p1_d = vld_p0 && (rcnt_q == '0);
      bin_p1_d  = bin_p0;
      bank_p1_d = rbank_q;
      rd_word   = bank_p1_q ? ram_rdata[1] : ram_rdata[0];
   end

   // Stage p2: output register; data and bin hold while no sample is valid.
   always_comb begin
      valid_d = vld_p1_q;
      sync_d  = vld_p1_q && sync_p1_q;
      bin_d   = vld_p1_q ? bin_p1_q : bin_q;
      re_d    = vld_p1_q ? $signed(rd_word[RW-1:DATA_WIDTH]) : re_q;
      im_d    = vld_p1_q ? $signed(rd_word[DATA_WIDTH-1:0]) : im_q;
   end

   // State, pipeline and output registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wstate_q  <= W_IDLE;
         wcnt_q    <= '0;
         wlen_q    <= '0;
         wbank_q   <= 1'b0;
         rstate_q  <= R_IDLE;
         rcnt_q    <= '0;
         rlen_q    <= '0;
         rbank_q   <= 1'b0;
         vld_p1_q  <= 1'b0;
         sync_p1_q <= 1'b0;
         bin_p1_q  <= '0;
         bank_p1_q <= 1'b0;
         valid_q   <= 1'b0;
         sync_q    <= 1'b0;
         bin_q     <= '0;
         re_q      <= '0;
         im_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         wstate_q  <= wstate_d;
         wcnt_q    <= wcnt_d;
         wlen_q    <= wlen_d;
         wbank_q   <= wbank_d;
         rstate_q  <= rstate_d;
         rcnt_q    <= rcnt_d;
         rlen_q    <= rlen_d;
         rbank_q   <= rbank_d;
         vld_p1_q  <= vld_p1_d;
         sync_p1_q <= sync_p1_d;
         bin_p1_q  <= bin_p1_d;
         bank_p1_q <= bank_p1_d;
         valid_q   <= valid_d;
         sync_q    <= sync_d;
         bin_q     <= bin_d;
         re_q      <= re_d;
         im_q      <= im_d;
         err_q     <= err_d;
      end
   end

   fft_reorder_bank_ram #(
      .ADDR_W (NW),
      .WIDTH  (RW)
   ) u_bank0 (
      .clk_i     (clk_i),
      .wr_en_i   (ram_we[0]),
      .wr_addr_i (wr_addr),
      .wr_data_i ({data_re_i, data_im_i}),
      .rd_en_i   (ram_re[0]),
      .rd_addr_i (raddr_p0),
      .rd_data_o (ram_rdata[0])
   );

   fft_reorder_bank_ram #(
      .ADDR_W (NW),
      .WIDTH  (RW)
   ) u_bank1 (
      .clk_i     (clk_i),
      .wr_en_i   (ram_we[1]),
      .wr_addr_i (wr_addr),
      .wr_data_i ({data_re_i, data_im_i}),
      .rd_en_i   (ram_re[1]),
      .rd_addr_i (raddr_p0),
      .rd_data_o (ram_rdata[1])
   );

   // Fill of a frame always takes at least as long as the drain of the previous
   // one, so a handoff never interrupts a drain before its final cycle.
   a_handoff_on_last: assert property (@(posedge clk_i) disable iff (!rst_n)
      (hand_v && rstate_q == R_DRAIN) |-> rlast);

   assign valid_o     = valid_q;
   assign sync_o      = sync_q;
   assign bin_o       = bin_q;
   assign data_re_o   = re_q;
   assign data_im_o   = im_q;
   assign frame_err_o = err_q;

endmodule

// File: tb/tb_fft_reorder_pingpong.sv
// Bench for fft_reorder_pingpong: frames are defined by their natural-order
// bins, sent in bit-reversed order, and the expected natural-order stream is
// queued for a per-cycle compare process.
module tb_fft_reorder_pingpong;

   localparam int N  = 10;
   localparam int DW = 25;
   localparam int LW = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_n = 1'b1;
   logic [LW-1:0]        len_log2_i = '0;
   logic                 valid_i = 1'b0;
   logic                 sync_i = 1'b0;
   logic signed [DW-1:0] data_re_i = '0;
   logic signed [DW-1:0] data_im_i = '0;
   logic                 valid_o;
   logic                 sync_o;
   logic [N-1:0]         bin_o;
   logic signed [DW-1:0] data_re_o;
   logic signed [DW-1:0] data_im_o;
   logic                 frame_err_o;

   always #5 clk_i = ~clk_i;

   fft_reorder_pingpong #(
      .N_LOG2_MAX (N),
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .len_log2_i  (len_log2_i),
      .valid_i     (valid_i),
      .sync_i      (sync_i),
      .data_re_i   (data_re_i),
      .data_im_i   (data_im_i),
      .valid_o     (valid_o),
      .sync_o      (sync_o),
      .bin_o       (bin_o),
      .data_re_o   (data_re_o),
      .data_im_o   (data_im_o),
      .frame_err_o (frame_err_o)
   );

   typedef struct {
      longint re;
      longint im;
      longint bin;
      bit     sync;
      bit     last;
   } exp_t;

   exp_t   exp_q[$];
   int     sync_edge_q[$];
   int     edge_cnt = 0;
   int     n_cmp = 0;
   int     n_fail = 0;
   int     err_cnt = 0;
   bit     in_frame = 1'b0;
   exp_t   e;
   longint cap_re [1024];
   longint cap_im [1024];
   longint cap_bin[1024];
   int     cap_pos = 0;

   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int brev(input int v, input int l);
      int r = 0;
      for (int i = 0; i < l; i++) r |= ((v >> i) & 1) << (l - 1 - i);
      return r;
   endfunction

   function automatic int clampl(input int f);
      return (f < 2 || f > N) ? N : f;
   endfunction

   task automatic drive(input bit v, input bit s, input int len,
                        input longint re, input longint im);
      valid_i    = v;
      sync_i     = s;
      len_log2_i = LW'(len);
      data_re_i  = DW'(re);
      data_im_i  = DW'(im);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0, 0);
   endtask

   // kind 0: ramp re=b, im=-b; kind 1: random; kind 2: impulse at bin 0.
   task automatic send_frame(input int len_field, input int gap, input int kind);
      int     l = clampl(len_field);
      int     n = 1 << l;
      int     half = n / 2;
      longint xr[1024];
      longint xi[1024];
      logic signed [DW-1:0] t;
      exp_t   x;
      for (int b = 0; b < n; b++) begin
         if (kind == 0) begin
            xr[b] = b; xi[b] = -b;
         end else if (kind == 1) begin
            t = DW'($urandom); xr[b] = t;
            t = DW'($urandom); xi[b] = t;
         end else begin
            xr[b] = (b == 0) ? 1000 : 0; xi[b] = 0;
         end
      end
      for (int i = 0; i < n; i++) begin
         // Idle gap cycles carry a stray sync that must be ignored.
         for (int g = 0; g < gap; g++) drive(1'b0, 1'b1, 0, $urandom, $urandom);
         drive(1'b1, i == 0, len_field, xr[brev(i, l)], xi[brev(i, l)]);
      end
      for (int p = 0; p < n; p++) begin
`ifdef FFT_REORDER_FFTSHIFT_EN
         x.re  = xr[p ^ half];
         x.im  = xi[p ^ half];
         x.bin = longint'((p - half) & ((1 << N) - 1));
`else
         x.re  = xr[p];
         x.im  = xi[p];
         x.bin = p;
`endif
         x.sync = (p == 0);
         x.last = (p == n - 1);
         exp_q.push_back(x);
      end
      sync_edge_q.push_back(edge_cnt + 2);
   endtask

   // Per-cycle comparison of the output stream against the queued model.
   always @(negedge clk_i) begin
      if (!rst_n) begin
         in_frame = 1'b0;
      end else begin
         if (frame_err_o) err_cnt++;
         if (valid_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("data_re", longint'(data_re_o), e.re);
               chk("data_im", longint'(data_im_o), e.im);
               chk("bin", longint'(bin_o), e.bin);
               chk("sync", longint'(sync_o), longint'(e.sync));
               if (e.sync) begin
                  cap_pos = 0;
                  if (sync_edge_q.size() > 0) chk("latency_edge", edge_cnt, sync_edge_q.pop_front());
                  else chk("latency_missing", 0, 1);
               end
               if (cap_pos < 1024) begin
                  cap_re[cap_pos]  = longint'(data_re_o);
                  cap_im[cap_pos]  = longint'(data_im_o);
                  cap_bin[cap_pos] = longint'(bin_o);
               end
               cap_pos++;
               in_frame = !e.last;
            end
         end else if (in_frame) begin
            chk("valid_gap", 0, 1);
            in_frame = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int err0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", longint'(valid_o), 0);
      chk("rst_sync", longint'(sync_o), 0);
      chk("rst_bin", longint'(bin_o), 0);
      chk("rst_re", longint'(data_re_o), 0);
      chk("rst_err", longint'(frame_err_o), 0);
      repeat (3) @(posedge clk_i);
      #1 rst_n = 1'b1;
      idle(3);
      chk("post_rst_valid", longint'(valid_o), 0);

      // Ramp, L=4
      send_frame(4, 0, 0);
      idle(30);
`ifndef FFT_REORDER_FFTSHIFT_EN
      chk("ramp_re0", cap_re[0], 0);
      chk("ramp_re1", cap_re[1], 1);
      chk("ramp_re8", cap_re[8], 8);
      chk("ramp_im15", cap_im[15], -15);
      chk("ramp_bin15", cap_bin[15], 15);
      chk("ramp_count", cap_pos, 16);
      chk("hold_re", longint'(data_re_o), 15);
`else
      send_frame(4, 0, 2);
      idle(30);
      chk("shift_re8", cap_re[8], 1000);
      chk("shift_re0", cap_re[0], 0);
      chk("shift_bin0", cap_bin[0], 1024 - 8);
      chk("shift_bin8", cap_bin[8], 0);
      chk("shift_bin15", cap_bin[15], 7);
`endif

      // Back-to-back, three L=10 frames
      send_frame(10, 0, 1);
      send_frame(10, 0, 1);
      send_frame(10, 0, 1);
      idle(1040);
      chk("b2b_drained", exp_q.size(), 0);

      // Stray valid samples without sync are dropped, then gapped L=6
      drive(1'b1, 1'b0, 6, 11, 22);
      drive(1'b1, 1'b0, 6, 33, 44);
      send_frame(6, 2, 1);
      send_frame(6, 2, 1);
      idle(80);
      chk("gap_count", cap_pos, 64);
      chk("no_err_yet", err_cnt, 0);

      // Early sync at sample 5 of an L=5 frame
      err0 = err_cnt;
      for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 5, 777, 777);
      send_frame(5, 0, 1);
      idle(45);
      chk("early_err_pulses", err_cnt - err0, 1);
      chk("early_count", cap_pos, 32);

      // Mixed lengths, clamp, then reset mid-drain
      send_frame(3, 0, 1);
      send_frame(8, 0, 1);
      send_frame(15, 0, 1);
      idle(300);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", longint'(valid_o), 0);
      chk("midrst_re", longint'(data_re_o), 0);
      exp_q.delete();
      sync_edge_q.delete();
      @(posedge clk_i);
      #1;
      idle(2);
      rst_n = 1'b1;
      idle(20);
      chk("after_rst_valid", longint'(valid_o), 0);

      chk("final_exp_empty", exp_q.size(), 0);
      chk("final_sync_empty", sync_edge_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
